// File: rtl/fused_dequantizer_if.sv
// Beat-level bus for the INT4 -> INT8 dequantizer: operand side plus registered result side.
// valid_in qualifies int4_in/scale/offset on a rising edge; there is no ready, the block never stalls.
interface fused_dequantizer_if #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 8
);
    logic             valid_in;
    logic [IN_W-1:0]  int4_in;
    logic [IN_W-1:0]  scale;
    logic [IN_W-1:0]  offset;
    logic [OUT_W-1:0] int8_out;
    logic             valid_out;

    modport master (
        output valid_in, int4_in, scale, offset,
        input  int8_out, valid_out
    );

    modport slave (
        input  valid_in, int4_in, scale, offset,
        output int8_out, valid_out
    );
endinterface

// File: rtl/fused_dequantizer.sv
// Single-stage dequantizer: out = clamp((int4_in - offset) * scale, 0, 2^OUT_W-1),
// registered once; int8_out holds its last value on idle beats.
module fused_dequantizer #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 8
) (
    input logic                clk,
    input logic                rst,
    fused_dequantizer_if.slave bus
);
    localparam int PW = 2 * IN_W + 2;
    localparam int CW = (PW > OUT_W + 1) ? PW : OUT_W + 1;
    localparam logic [OUT_W:0] OUT_MAX = {1'b0, {OUT_W{1'b1}}};

    logic [IN_W:0]    diff;
    logic [PW-1:0]    prod;
    logic [CW-1:0]    prod_c;
    logic [OUT_W-1:0] clamped;

    // diff is two's complement; sign-extending it and zero-extending scale lets a
    // plain unsigned multiply produce the correct signed product in PW bits.
    always_comb begin
        diff    = {1'b0, bus.int4_in} - {1'b0, bus.offset};
        prod    = {{(IN_W + 1){diff[IN_W]}}, diff} * {{(IN_W + 2){1'b0}}, bus.scale};
        prod_c  = CW'(prod);
        clamped = '0;
        if (prod[PW-1]) begin
            clamped = '0;
        end else if (prod_c > CW'(OUT_MAX)) begin
            clamped = {OUT_W{1'b1}};
        end else begin
            clamped = OUT_W'(prod_c);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.int8_out  <= '0;
            bus.valid_out <= 1'b0;
        end else begin
            bus.valid_out <= bus.valid_in;
            if (bus.valid_in) begin
                bus.int8_out <= clamped;
            end
        end
    end
endmodule

// File: tb/tb_fused_dequantizer.sv
// Directed bench for fused_dequantizer: hand-computed vectors, immediate assertions, one summary line.
module tb_fused_dequantizer;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    fused_dequantizer_if #(.IN_W(4), .OUT_W(8)) bus ();

    fused_dequantizer #(.IN_W(4), .OUT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one beat, let one rising edge pass, return 2 time units after it.
    task automatic apply(input logic v, input logic [3:0] a, input logic [3:0] s,
                         input logic [3:0] o);
        bus.valid_in = v;
        bus.int4_in  = a;
        bus.scale    = s;
        bus.offset   = o;
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [7:0] exp_d, input logic exp_v);
        logic [8:0] obs;
        logic [8:0] exp;
        obs = {bus.int8_out, bus.valid_out};
        exp = {exp_d, exp_v};
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got out=%0d valid=%b, expected out=%0d valid=%b",
                   tag, obs[8:1], obs[0], exp[8:1], exp[0]);
        end
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        rst           = 1'b1;
        bus.valid_in  = 1'b0;
        bus.int4_in   = '0;
        bus.scale     = '0;
        bus.offset    = '0;
        #3;
        chk("reset_state", 8'd0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;

        apply(1'b1, 4'd6, 4'd5, 4'd0);   chk("six_times_five", 8'd30, 1'b1);
        apply(1'b0, 4'd1, 4'd1, 4'd0);   chk("hold_after_pulse", 8'd30, 1'b0);
        apply(1'b1, 4'd10, 4'd3, 4'd2);  chk("offset_sub", 8'd24, 1'b1);
        apply(1'b1, 4'd5, 4'd10, 4'd5);  chk("equal_offset", 8'd0, 1'b1);
        apply(1'b1, 4'd15, 4'd15, 4'd0); chk("max_product", 8'd225, 1'b1);
        apply(1'b1, 4'd0, 4'd10, 4'd0);  chk("zero_zero", 8'd0, 1'b1);
        apply(1'b1, 4'd1, 4'd1, 4'd0);   chk("one_by_one", 8'd1, 1'b1);
        apply(1'b1, 4'd8, 4'd1, 4'd0);   chk("eight_by_one", 8'd8, 1'b1);
        apply(1'b1, 4'd3, 4'd2, 4'd8);   chk("negative_clamp", 8'd0, 1'b1);
        apply(1'b1, 4'd9, 4'd7, 4'd2);   chk("nine_minus_two", 8'd49, 1'b1);
        apply(1'b1, 4'd9, 4'd0, 4'd3);   chk("scale_zero", 8'd0, 1'b1);
        apply(1'b1, 4'd13, 4'd11, 4'd1); chk("twelve_by_eleven", 8'd132, 1'b1);
        apply(1'b0, 4'd15, 4'd15, 4'd0); chk("idle_holds", 8'd132, 1'b0);

        // Back-to-back stream, valid_out must stay high on each result cycle.
        apply(1'b1, 4'd7, 4'd2, 4'd1);   chk("stream_0", 8'd12, 1'b1);
        apply(1'b1, 4'd9, 4'd3, 4'd4);   chk("stream_1", 8'd15, 1'b1);
        apply(1'b1, 4'd12, 4'd4, 4'd3);  chk("stream_2", 8'd36, 1'b1);
        apply(1'b0, 4'd0, 4'd0, 4'd0);   chk("stream_end", 8'd36, 1'b0);

        // Async reset between edges right after a 225 result.
        apply(1'b1, 4'd15, 4'd15, 4'd0); chk("pre_reset_225", 8'd225, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_reset_now", 8'd0, 1'b0);
        apply(1'b1, 4'd15, 4'd15, 4'd0); chk("reset_held", 8'd0, 1'b0);
        rst = 1'b0;
        apply(1'b1, 4'd2, 4'd7, 4'd0);   chk("after_release", 8'd14, 1'b1);
        apply(1'b0, 4'd0, 4'd0, 4'd0);   chk("after_release_idle", 8'd14, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
